// File: rtl/bcd_key_counter_if.sv
// Control and display bus of the two-digit BCD key counter.
// The master side drives keys, load and auto-count; the slave side is the counter itself.
interface bcd_key_counter_if;
  logic       key_up_n;
  logic       key_down_n;
  logic       load;
  logic [7:0] load_value;
  logic       auto_en;
  logic [7:0] count;
  logic       carry;
  logic       borrow;

  modport master (
    output key_up_n, key_down_n, load, load_value, auto_en,
    input  count, carry, borrow
  );

  modport slave (
    input  key_up_n, key_down_n, load, load_value, auto_en,
    output count, carry, borrow
  );
endinterface

// File: rtl/bcd_key_counter.sv
// Two-digit BCD up/down counter driven by debounced pushbuttons, a periodic auto tick and a load strobe.
// Index 0 of the per-key arrays is the up key, index 1 the down key.
module bcd_key_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 50000000
) (
  input logic              CLOCK_50,
  input logic              rst_n,
  bcd_key_counter_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);
  localparam logic [TK_W-1:0] TK_MAX  = TK_W'(TICK_CYCLES - 1);
  localparam logic [TK_W-1:0] TK_ONE  = TK_W'(1);
  localparam logic [TK_W-1:0] TK_ZERO = TK_W'(0);

  logic [1:0]      keys_s;
  logic [1:0]      sync0_r;
  logic [1:0]      sync1_r;
  logic [1:0]      db_r;
  logic [1:0]      evt_r;
  logic [DB_W-1:0] db_cnt_r [2];
  logic [TK_W-1:0] pre_r;
  logic            tick_s;
  logic            inc_s;
  logic            dec_s;
  logic [7:0]      count_r;
  logic            carry_r;
  logic            borrow_r;
  logic [7:0]      count_nx_s;
  logic            carry_nx_s;
  logic            borrow_nx_s;

  function automatic logic [7:0] bcd_sanitize(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (v[7:4] > 4'd9) ? 4'd0 : v[7:4];
    units = (v[3:0] > 4'd9) ? 4'd0 : v[3:0];
    return {tens, units};
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd0) begin
      units = 4'd9;
      tens  = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
    end else begin
      units = units - 4'd1;
    end
    return {tens, units};
  endfunction

  assign keys_s = {bus.key_down_n, bus.key_up_n};

  // Two-flop synchronizers; idle level is released (high).
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync0_r <= 2'b11;
      sync1_r <= 2'b11;
    end else begin
      sync0_r <= keys_s;
      sync1_r <= sync0_r;
    end
  end

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      db_r  <= 2'b11;
      evt_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= DB_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        evt_r[i] <= 1'b0;
        if (sync1_r[i] != db_r[i]) begin
          if (db_cnt_r[i] == DB_MAX) begin
            db_r[i]     <= sync1_r[i];
            db_cnt_r[i] <= DB_ZERO;
            evt_r[i]    <= ~sync1_r[i];
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
          end
        end else begin
          db_cnt_r[i] <= DB_ZERO;
        end
      end
    end
  end

  // Auto-count prescaler, parked at zero while auto counting is off.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= TK_ZERO;
    end else if (!bus.auto_en) begin
      pre_r <= TK_ZERO;
    end else if (pre_r == TK_MAX) begin
      pre_r <= TK_ZERO;
    end else begin
      pre_r <= pre_r + TK_ONE;
    end
  end

  // Count direction requests for this cycle.
  always_comb begin
    tick_s = bus.auto_en & (pre_r == TK_MAX);
    inc_s  = evt_r[0] | tick_s;
    dec_s  = evt_r[1];
  end

  // Next count: load wins, simultaneous up and down cancel.
  always_comb begin
    count_nx_s  = count_r;
    carry_nx_s  = 1'b0;
    borrow_nx_s = 1'b0;
    if (bus.load) begin
      count_nx_s = bcd_sanitize(bus.load_value);
    end else if (inc_s && dec_s) begin
      count_nx_s = count_r;
    end else if (inc_s) begin
      count_nx_s = bcd_inc(count_r);
      carry_nx_s = (count_r == 8'h99);
    end else if (dec_s) begin
      count_nx_s  = bcd_dec(count_r);
      borrow_nx_s = (count_r == 8'h00);
    end else begin
      count_nx_s = count_r;
    end
  end

  // Registered count and wrap pulses.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= 8'h00;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      count_r  <= count_nx_s;
      carry_r  <= carry_nx_s;
      borrow_r <= borrow_nx_s;
    end
  end

  assign bus.count  = count_r;
  assign bus.carry  = carry_r;
  assign bus.borrow = borrow_r;

endmodule

// File: tb/tb_bcd_key_counter.sv
// Scoreboard bench for bcd_key_counter: a decimal reference model predicts count/carry/borrow
// after every clock edge and a monitor compares the DUT against those predictions.
module tb_bcd_key_counter;
  localparam int D = 4;
  localparam int T = 8;

  logic CLOCK_50 = 1'b0;
  logic rst_n;

  bcd_key_counter_if bus();

  bcd_key_counter #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .bus      (bus.slave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] count;
    logic       carry;
    logic       borrow;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   fail_prints = 0;

  // Reference model state: count as a plain integer 0..99.
  int   m_val;
  int   m_pc;
  bit   m_pipe [2][2];
  bit   m_hist [2][D];
  int   m_valid [2];
  bit   m_db [2];
  bit   m_pend [2];
  bit   m_raw [2];
  bit   m_tick, m_inc, m_dec, m_cy, m_bw, m_sample, m_all;
  exp_t m_e;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic int load_to_int(input logic [7:0] lv);
    int t;
    int u;
    t = int'(lv[7:4]);
    u = int'(lv[3:0]);
    if (t > 9) t = 0;
    if (u > 9) u = 0;
    return t * 10 + u;
  endfunction

  // Model: evaluated at each rising edge with the inputs present at that edge.
  initial forever begin
    @(posedge CLOCK_50);
    if (!rst_n) begin
      m_val = 0;
      m_pc  = 0;
      for (int k = 0; k < 2; k++) begin
        m_pipe[k][0] = 1'b1;
        m_pipe[k][1] = 1'b1;
        m_valid[k]   = 0;
        m_db[k]      = 1'b1;
        m_pend[k]    = 1'b0;
      end
      m_e = '0;
      exp_q.push_back(m_e);
    end else begin
      m_tick = bus.auto_en && (m_pc == T - 1);
      m_inc  = m_pend[0] || m_tick;
      m_dec  = m_pend[1];
      m_cy   = 1'b0;
      m_bw   = 1'b0;
      if (bus.load) begin
        m_val = load_to_int(bus.load_value);
      end else if (m_inc && !m_dec) begin
        m_cy  = (m_val == 99);
        m_val = (m_val + 1) % 100;
      end else if (m_dec && !m_inc) begin
        m_bw  = (m_val == 0);
        m_val = (m_val + 99) % 100;
      end
      m_pc = bus.auto_en ? (m_pc + 1) % T : 0;
      m_raw[0] = bus.key_up_n;
      m_raw[1] = bus.key_down_n;
      for (int k = 0; k < 2; k++) begin
        m_sample     = m_pipe[k][1];
        m_pipe[k][1] = m_pipe[k][0];
        m_pipe[k][0] = m_raw[k];
        for (int j = D - 1; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
        m_hist[k][0] = m_sample;
        if (m_valid[k] < D) m_valid[k]++;
        m_pend[k] = 1'b0;
        m_all = (m_valid[k] >= D);
        for (int j = 0; j < D; j++) if (m_hist[k][j] == m_db[k]) m_all = 1'b0;
        // D differing samples in a row: accept the new level; only a press makes an event.
        if (m_all) begin
          m_db[k]    = m_sample;
          m_valid[k] = 0;
          m_pend[k]  = (m_sample == 1'b0);
        end
      end
      m_e.count  = to_bcd(m_val);
      m_e.carry  = m_cy;
      m_e.borrow = m_bw;
      exp_q.push_back(m_e);
    end
  end

  // Monitor: one prediction per edge, compared on the following falling edge.
  initial begin
    exp_t e;
    @(posedge CLOCK_50);
    forever begin
      @(negedge CLOCK_50);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        if (fail_prints < 20) $display("FAIL scoreboard_empty t=%0t: no prediction available", $time);
        fail_prints++;
      end else begin
        e = exp_q.pop_front();
        if (!rst_n) e = '0;
        if ({bus.count, bus.carry, bus.borrow} !== e) begin
          errors++;
          if (fail_prints < 20)
            $display("FAIL scoreboard t=%0t: count=%h carry=%b borrow=%b, expected count=%h carry=%b borrow=%b",
                     $time, bus.count, bus.carry, bus.borrow, e.count, e.carry, e.borrow);
          fail_prints++;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic press(input bit down, input int low_n, input int high_n);
    if (down) bus.key_down_n = 1'b0; else bus.key_up_n = 1'b0;
    cyc(low_n);
    if (down) bus.key_down_n = 1'b1; else bus.key_up_n = 1'b1;
    cyc(high_n);
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load       = 1'b1;
    bus.load_value = v;
    cyc(1);
    bus.load = 1'b0;
    cyc(2);
  endtask

  initial begin
    int guard;
    rst_n          = 1'b0;
    bus.key_up_n   = 1'b1;
    bus.key_down_n = 1'b1;
    bus.load       = 1'b0;
    bus.load_value = 8'h00;
    bus.auto_en    = 1'b0;
    cyc(3);
    chk("reset_state", {bus.count, bus.carry, bus.borrow}, 10'h000);
    rst_n = 1'b1;
    cyc(2);

    press(1'b0, 20, 10);
    chk("up_hold_once", {2'b00, bus.count}, {2'b00, 8'h01});
    press(1'b1, 2, 10);
    chk("short_glitch", {2'b00, bus.count}, {2'b00, 8'h01});

    do_load(8'h99);
    chk("load_99", {2'b00, bus.count}, {2'b00, 8'h99});
    press(1'b0, 8, 8);
    chk("wrap_up", {2'b00, bus.count}, {2'b00, 8'h00});
    press(1'b1, 8, 8);
    chk("wrap_down", {2'b00, bus.count}, {2'b00, 8'h99});

    do_load(8'hA7);
    chk("load_a7", {2'b00, bus.count}, {2'b00, 8'h07});
    do_load(8'h3F);
    chk("load_3f", {2'b00, bus.count}, {2'b00, 8'h30});

    do_load(8'h08);
    bus.auto_en = 1'b1;
    cyc(24);
    chk("auto_three_ticks", {2'b00, bus.count}, {2'b00, 8'h11});
    // Launch a down press whose event lands on the same edge as the next tick.
    guard = 0;
    while (m_pc != 1 && guard < 20) begin
      cyc(1);
      guard++;
    end
    chk("tick_align_found", {9'd0, guard < 20}, 10'd1);
    bus.key_down_n = 1'b0;
    cyc(7);
    chk("down_plus_tick", {2'b00, bus.count}, {2'b00, 8'h11});
    bus.key_down_n = 1'b1;
    bus.auto_en    = 1'b0;
    cyc(10);

    do_load(8'h42);
    bus.key_up_n = 1'b0;
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("reset_async", {2'b00, bus.count}, {2'b00, 8'h00});
    bus.key_up_n = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(15);
    chk("no_stray_event", {2'b00, bus.count}, {2'b00, 8'h00});

    bus.key_down_n = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(12);
    chk("held_through_reset", {2'b00, bus.count}, {2'b00, 8'h99});
    bus.key_down_n = 1'b1;
    cyc(10);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.key_up_n = ~bus.key_up_n;
      if ($urandom_range(0, 5) == 0) bus.key_down_n = ~bus.key_down_n;
      if ($urandom_range(0, 39) == 0) bus.auto_en = ~bus.auto_en;
      bus.load       = ($urandom_range(0, 29) == 0);
      bus.load_value = 8'($urandom);
      cyc(1);
    end
    bus.load = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
